// File: rtl/mem_port_arbiter.sv
// Sequencer for the CPU's single-port memory, arbitrating data > stack > fetch.
// Define MEM_ARB_FAIR_EN to force a starved fetch through after STARVE_MAX lost arbitrations.
module mem_port_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          ds_req,
    input  logic          ds_we,
    input  logic [AW-1:0] ds_addr,
    input  logic [DW-1:0] ds_wdata,
    output logic          ds_gnt,
    output logic          ds_rvalid,
    input  logic          sk_req,
    input  logic          sk_push,
    input  logic [AW-1:0] sk_sp,
    input  logic [DW-1:0] sk_wdata,
    output logic          sk_gnt,
    output logic          sk_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          MW,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          IorD,
    output logic          MSrc,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Requester vectors are one-hot: bit 0 = fetch, bit 1 = data, bit 2 = stack.
    state_t        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d, own_q, own_d, rvalid_q, rvalid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic          mw_q, mw_d, iord_q, iord_d, msrc_q, msrc_d;
    logic          arbEdge, fetchForce;
    logic [2:0]    reqEff, win;

`ifdef MEM_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign fetchForce = (starve_q == CW'(STARVE_MAX));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) starve_q <= '0;
        else        starve_q <= starve_d;
    end

    always_comb begin
        starve_d = starve_q;
        if (arbEdge) begin
            if (win[0])         starve_d = '0;
            else if (reqEff[0]) starve_d = starve_q + 1'b1;
        end
    end
`else
    assign fetchForce = (STARVE_MAX < 0);
`endif

    // The requester owning a write ACCESS is masked at the edge that closes its grant cycle.
    always_comb begin
        arbEdge = (state_q == IDLE) || (state_q == RESP) || (state_q == ACCESS && mw_q);
        reqEff  = {sk_req, ds_req, if_req};
        if (state_q == ACCESS) reqEff = reqEff & ~own_q;
        win = 3'b000;
        if (reqEff[0] && fetchForce) win = 3'b001;
        else if (reqEff[1])          win = 3'b010;
        else if (reqEff[2])          win = 3'b100;
        else if (reqEff[0])          win = 3'b001;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = 3'b000;
        rvalid_d = 3'b000;
        own_d    = own_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mw_d     = mw_q;
        iord_d   = iord_q;
        msrc_d   = msrc_q;
        if (state_q == ACCESS && !mw_q) state_d = RESP;
        if (state_q == RESP) begin
            rdata_d  = mem_rdata;
            rvalid_d = own_q;
        end
        if (arbEdge) begin
            state_d = IDLE;
            mw_d    = 1'b0;
            if (win != 3'b000) begin
                state_d = ACCESS;
                gnt_d   = win;
                own_d   = win;
                iord_d  = !win[0];
                msrc_d  = win[2];
                if (win[1]) begin
                    addr_d  = ds_addr;
                    wdata_d = ds_wdata;
                    mw_d    = ds_we;
                end else if (win[2]) begin
                    addr_d  = sk_sp;
                    wdata_d = sk_wdata;
                    mw_d    = sk_push;
                end else begin
                    addr_d  = if_addr;
                    wdata_d = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            own_q    <= 3'b000;
            rvalid_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mw_q     <= 1'b0;
            iord_q   <= 1'b0;
            msrc_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            own_q    <= own_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mw_q     <= mw_d;
            iord_q   <= iord_d;
            msrc_q   <= msrc_d;
        end
    end

    assign if_gnt    = gnt_q[0];
    assign ds_gnt    = gnt_q[1];
    assign sk_gnt    = gnt_q[2];
    assign if_rvalid = rvalid_q[0];
    assign ds_rvalid = rvalid_q[1];
    assign sk_rvalid = rvalid_q[2];
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign MW        = mw_q;
    assign rdata     = rdata_q;
    assign IorD      = iord_q;
    assign MSrc      = msrc_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and read returns are queued with
// the edge they must appear on, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    logic        CLK   = 1'b0;
    logic        RST_N = 1'b1;
    logic        if_req, ds_req, ds_we, sk_req, sk_push;
    logic [15:0] if_addr, ds_addr, ds_wdata, sk_sp, sk_wdata;
    logic        if_gnt, if_rvalid, ds_gnt, ds_rvalid, sk_gnt, sk_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic        MW, IorD, MSrc, busy;

    typedef struct {
        int          kind;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        int          at;
    } gntExp_t;
    typedef struct {
        int          kind;
        logic [15:0] data;
        int          at;
    } rvExp_t;

    gntExp_t     gntQ[$];
    rvExp_t      rvQ[$];
    gntExp_t     gE;
    rvExp_t      rE;
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    int          c0;
    bit          dsAuto = 1'b1;
    logic [15:0] mem [0:255];

    mem_port_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
        .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid),
        .sk_req(sk_req), .sk_push(sk_push), .sk_sp(sk_sp), .sk_wdata(sk_wdata),
        .sk_gnt(sk_gnt), .sk_rvalid(sk_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MW(MW), .mem_rdata(mem_rdata),
        .rdata(rdata), .IorD(IorD), .MSrc(MSrc), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous single-port memory: writes commit at the edge, read data follows one cycle later.
    always @(posedge CLK) begin
        if (MW) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int kind, input logic we, input logic [15:0] addr,
                                 input logic [15:0] data);
        case (kind)
            0: begin if_req = 1'b1; if_addr = addr; end
            1: begin ds_req = 1'b1; ds_we = we; ds_addr = addr; ds_wdata = data; end
            default: begin sk_req = 1'b1; sk_push = we; sk_sp = addr; sk_wdata = data; end
        endcase
    endtask

    task automatic expectGnt(input int kind, input logic we, input logic [15:0] addr,
                             input logic [15:0] data, input int at);
        gntQ.push_back('{kind: kind, we: we, addr: addr, data: data, at: at});
    endtask

    task automatic expectRv(input int kind, input logic [15:0] data, input int at);
        rvQ.push_back('{kind: kind, data: data, at: at});
    endtask

    // A requester drops its req after the edge that closes the cycle its gnt was high.
    task automatic stepCycle();
        logic [2:0] g;
        g = {sk_gnt, ds_gnt, if_gnt};
        @(posedge CLK);
        #1;
        if (g[0]) if_req = 1'b0;
        if (g[1] && dsAuto) ds_req = 1'b0;
        if (g[2]) sk_req = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            if ({sk_gnt, ds_gnt, if_gnt} != 3'b000) begin
                if (gntQ.size() == 0) begin
                    checkOutput("gnt_spurious", 32'({sk_gnt, ds_gnt, if_gnt}), 32'd0);
                end else begin
                    gE = gntQ.pop_front();
                    checkOutput("gnt_who", 32'({sk_gnt, ds_gnt, if_gnt}), 32'(1 << gE.kind));
                    checkOutput("gnt_cycle", 32'(cyc), 32'(gE.at));
                    checkOutput("gnt_MW", 32'(MW), 32'(gE.we));
                    checkOutput("gnt_IorD", 32'(IorD), 32'(gE.kind != 0));
                    checkOutput("gnt_MSrc", 32'(MSrc), 32'(gE.kind == 2));
                    checkOutput("gnt_addr", 32'(mem_addr), 32'(gE.addr));
                    if (gE.we) checkOutput("gnt_wdata", 32'(mem_wdata), 32'(gE.data));
                end
            end
            if ({sk_rvalid, ds_rvalid, if_rvalid} != 3'b000) begin
                if (rvQ.size() == 0) begin
                    checkOutput("rv_spurious", 32'({sk_rvalid, ds_rvalid, if_rvalid}), 32'd0);
                end else begin
                    rE = rvQ.pop_front();
                    checkOutput("rv_who", 32'({sk_rvalid, ds_rvalid, if_rvalid}), 32'(1 << rE.kind));
                    checkOutput("rv_cycle", 32'(cyc), 32'(rE.at));
                    checkOutput("rv_rdata", 32'(rdata), 32'(rE.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        if_req = 0; ds_req = 0; sk_req = 0; ds_we = 0; sk_push = 0;
        if_addr = 0; ds_addr = 0; ds_wdata = 0; sk_sp = 0; sk_wdata = 0;
        #2 RST_N = 1'b0;
        repeat (2) stepCycle();
        checkOutput("rst_gnt", 32'({sk_gnt, ds_gnt, if_gnt}), 32'd0);
        checkOutput("rst_rvalid", 32'({sk_rvalid, ds_rvalid, if_rvalid}), 32'd0);
        checkOutput("rst_ctrl", 32'({MW, IorD, MSrc, busy}), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        RST_N = 1'b1;
        stepCycle();

        // Seed SP 0x0001 with 0x1111 so the interrupted push below is observable.
        c0 = cyc;
        applyStimulus(2, 1'b1, 16'h0001, 16'h1111);
        expectGnt(2, 1'b1, 16'h0001, 16'h1111, c0 + 1);
        repeat (3) stepCycle();

        c0 = cyc;
        applyStimulus(2, 1'b1, 16'h0001, 16'h0022);
        stepCycle();
        checkOutput("rstmid_gnt", 32'(sk_gnt), 32'd1);
        checkOutput("rstmid_mw_pre", 32'(MW), 32'd1);
        RST_N = 1'b0;
        sk_req = 1'b0;
        #1;
        checkOutput("rstmid_mw", 32'(MW), 32'd0);
        checkOutput("rstmid_gnt_clr", 32'({sk_gnt, ds_gnt, if_gnt}), 32'd0);
        checkOutput("rstmid_ctrl", 32'({IorD, MSrc, busy}), 32'd0);
        checkOutput("rstmid_addr", 32'(mem_addr), 32'd0);
        repeat (2) stepCycle();
        RST_N = 1'b1;
        stepCycle();

        c0 = cyc;
        applyStimulus(2, 1'b0, 16'h0001, 16'h0000);
        expectGnt(2, 1'b0, 16'h0001, 16'h0000, c0 + 1);
        expectRv(2, 16'h1111, c0 + 3);
        repeat (4) stepCycle();

        c0 = cyc;
        applyStimulus(2, 1'b1, 16'h0001, 16'h0022);
        expectGnt(2, 1'b1, 16'h0001, 16'h0022, c0 + 1);
        repeat (3) stepCycle();
        c0 = cyc;
        applyStimulus(2, 1'b0, 16'h0001, 16'h0000);
        expectGnt(2, 1'b0, 16'h0001, 16'h0000, c0 + 1);
        expectRv(2, 16'h0022, c0 + 3);
        repeat (4) stepCycle();

        c0 = cyc;
        applyStimulus(1, 1'b1, 16'h00F3, 16'hFF00);
        expectGnt(1, 1'b1, 16'h00F3, 16'hFF00, c0 + 1);
        repeat (3) stepCycle();
        c0 = cyc;
        applyStimulus(1, 1'b0, 16'h00F3, 16'h0000);
        expectGnt(1, 1'b0, 16'h00F3, 16'h0000, c0 + 1);
        expectRv(1, 16'hFF00, c0 + 3);
        repeat (4) stepCycle();

        // Two writes arriving together go out on consecutive cycles.
        c0 = cyc;
        applyStimulus(1, 1'b1, 16'h0002, 16'h0744);
        applyStimulus(2, 1'b1, 16'h0000, 16'hBEEF);
        expectGnt(1, 1'b1, 16'h0002, 16'h0744, c0 + 1);
        expectGnt(2, 1'b1, 16'h0000, 16'hBEEF, c0 + 2);
        repeat (4) stepCycle();

        c0 = cyc;
        applyStimulus(1, 1'b0, 16'h0002, 16'h0000);
        applyStimulus(2, 1'b0, 16'h0001, 16'h0000);
        applyStimulus(0, 1'b0, 16'h0000, 16'h0000);
        expectGnt(1, 1'b0, 16'h0002, 16'h0000, c0 + 1);
        expectGnt(2, 1'b0, 16'h0001, 16'h0000, c0 + 3);
        expectGnt(0, 1'b0, 16'h0000, 16'h0000, c0 + 5);
        expectRv(1, 16'h0744, c0 + 3);
        expectRv(2, 16'h0022, c0 + 5);
        expectRv(0, 16'hBEEF, c0 + 7);
        repeat (9) stepCycle();

        // Fetch competing with a continuously held data load.
        c0 = cyc;
        dsAuto = 1'b0;
        applyStimulus(1, 1'b0, 16'h00F3, 16'h0000);
        applyStimulus(0, 1'b0, 16'h0000, 16'h0000);
`ifdef MEM_ARB_FAIR_EN
        for (int k = 0; k < 4; k++) begin
            expectGnt(1, 1'b0, 16'h00F3, 16'h0000, c0 + 1 + 2 * k);
            expectRv(1, 16'hFF00, c0 + 3 + 2 * k);
        end
        expectGnt(0, 1'b0, 16'h0000, 16'h0000, c0 + 9);
        expectRv(0, 16'hBEEF, c0 + 11);
        expectGnt(1, 1'b0, 16'h00F3, 16'h0000, c0 + 11);
        expectRv(1, 16'hFF00, c0 + 13);
`else
        for (int k = 0; k < 6; k++) begin
            expectGnt(1, 1'b0, 16'h00F3, 16'h0000, c0 + 1 + 2 * k);
            expectRv(1, 16'hFF00, c0 + 3 + 2 * k);
        end
        expectGnt(0, 1'b0, 16'h0000, 16'h0000, c0 + 13);
        expectRv(0, 16'hBEEF, c0 + 15);
`endif
        repeat (11) stepCycle();
        ds_req = 1'b0;
        dsAuto = 1'b1;
        repeat (6) stepCycle();

        // Store req held one extra edge: exactly one new write, with data sampled at that edge.
        c0 = cyc;
        dsAuto = 1'b0;
        applyStimulus(1, 1'b1, 16'h0010, 16'h5555);
        expectGnt(1, 1'b1, 16'h0010, 16'h5555, c0 + 1);
        expectGnt(1, 1'b1, 16'h0010, 16'h6666, c0 + 3);
        stepCycle();
        ds_wdata = 16'h6666;
        repeat (3) stepCycle();
        ds_req = 1'b0;
        dsAuto = 1'b1;
        stepCycle();
        c0 = cyc;
        applyStimulus(1, 1'b0, 16'h0010, 16'h0000);
        expectGnt(1, 1'b0, 16'h0010, 16'h0000, c0 + 1);
        expectRv(1, 16'h6666, c0 + 3);
        repeat (5) stepCycle();

        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("rdata_hold", 32'(rdata), 32'h6666);
        checkOutput("gnt_missing", 32'(gntQ.size()), 32'd0);
        checkOutput("rv_missing", 32'(rvQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
